// File: rtl/axil_pkg.sv
// Shared AXI4-Lite RAM slave definitions: response codes and FSM state encodings.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package axil_pkg;

  // Response codes driven on bresp/rresp
  localparam logic [1:0] AXIL_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXIL_RESP_SLVERR = 2'b10;

  // Write side: waiting for AW/W, holding one of them, or presenting the response
  typedef enum logic [1:0] {
    W_IDLE    = 2'd0,
    W_COLLECT = 2'd1,
    W_RESP    = 2'd2
  } wr_state_t;

  // Read side: accepting an address, or presenting registered read data
  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

endpackage

// File: rtl/axil_ram_slave_if.sv
// AXI4-Lite bundle (AW, W, B, AR, R channels) with master and slave views.
// Latency: none (wires only).
// Backpressure: standard valid/ready on every channel.
interface axil_ram_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  // Write address channel
  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  awvalid;
  logic                  awready;

  // Write data channel (full-word writes, no strobes)
  logic [DATA_WIDTH-1:0] wdata;
  logic                  wvalid;
  logic                  wready;

  // Write response channel
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  // Read address channel
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;

  // Read data channel
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/axil_ram_core.sv
// Word RAM with one synchronous write port and one synchronous read port.
// Latency: read data valid the cycle after rd_en; a same-edge write is not visible (old data returned).
// Backpressure: none; the read register holds its value while rd_en is low.
module axil_ram_core #(
  parameter int DEPTH_WORDS = 1024,
  parameter int DATA_WIDTH  = 32,
  localparam int IDX_W      = $clog2(DEPTH_WORDS)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  // Storage array: written on the clock edge, never reset so contents survive rstn
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  // Read register: captures the pre-write word on rd_en and holds it otherwise
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_idx];
    end
  end

endmodule

// File: rtl/axil_ram_slave.sv
// AXI4-Lite slave in front of a word RAM; AW/W accepted independently, reads and writes run concurrently.
// Latency: B one cycle after both AW and W are held (write lands that edge); R one cycle after the AR handshake.
// Backpressure: B and R are held until bready/rready; AXIL_RAM_SLAVE_ERR_EN enables SLVERR on out-of-window addresses.
module axil_ram_slave
  import axil_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    DEPTH_WORDS = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0
) (
  input  logic            clk,
  input  logic            rstn,
  axil_ram_slave_if.slave s_axil
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  // Word index relative to the base; the byte offset is dropped and the index wraps at the RAM depth
  function automatic logic [IDX_W-1:0] word_index(input logic [ADDR_WIDTH-1:0] a);
    return IDX_W'((a - BASE_ADDR) >> 2);
  endfunction

`ifdef AXIL_RAM_SLAVE_ERR_EN
  // Window bounds carry one extra bit so BASE_ADDR + 4*DEPTH cannot overflow
  localparam logic [ADDR_WIDTH:0] BASE_EXT  = {1'b0, BASE_ADDR};
  localparam logic [ADDR_WIDTH:0] LIMIT_EXT = BASE_EXT + (ADDR_WIDTH+1)'(4 * DEPTH_WORDS);

  function automatic logic out_of_range(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH:0] a_ext;
    a_ext = {1'b0, a};
    return (a_ext < BASE_EXT) || (a_ext >= LIMIT_EXT);
  endfunction
`endif

  // Ready gate: forces every ready low until the first edge after reset release
  logic                  rdy_en;

  // Write side state
  wr_state_t             wr_state, wr_state_d;
  logic                  aw_held, w_held;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [1:0]            bresp_q;
  logic                  aw_rdy, w_rdy, aw_fire, w_fire, b_fire;
  logic                  wr_commit, wr_err;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [IDX_W-1:0]      wr_idx;

  // Read side state
  rd_state_t             rd_state, rd_state_d;
  logic [1:0]            rresp_q;
  logic                  rd_err_q;
  logic                  ar_rdy, ar_fire, rd_err;
  logic [IDX_W-1:0]      rd_idx;
  logic [DATA_WIDTH-1:0] ram_rd_data;

  // Whichever half of the write is already held wins; otherwise take it straight off the bus
  assign wr_addr = aw_held ? aw_addr_q : s_axil.awaddr;
  assign wr_data = w_held  ? w_data_q  : s_axil.wdata;
  assign wr_idx  = word_index(wr_addr);
  assign rd_idx  = word_index(s_axil.araddr);

`ifdef AXIL_RAM_SLAVE_ERR_EN
  assign wr_err = out_of_range(wr_addr);
  assign rd_err = out_of_range(s_axil.araddr);
`else
  assign wr_err = 1'b0;
  assign rd_err = 1'b0;
`endif

  // Ready gate register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdy_en <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
    end
  end

  // Write FSM state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_state <= W_IDLE;
    end else begin
      wr_state <= wr_state_d;
    end
  end

  // Write FSM next state, channel readies and the commit decision
  always_comb begin
    wr_state_d = wr_state;
    aw_rdy     = rdy_en && (wr_state != W_RESP) && !aw_held;
    w_rdy      = rdy_en && (wr_state != W_RESP) && !w_held;
    aw_fire    = s_axil.awvalid && aw_rdy;
    w_fire     = s_axil.wvalid && w_rdy;
    b_fire     = (wr_state == W_RESP) && s_axil.bready;
    wr_commit  = (wr_state != W_RESP) && (aw_held || aw_fire) && (w_held || w_fire);
    case (wr_state)
      W_IDLE: begin
        if (wr_commit) begin
          wr_state_d = W_RESP;
        end else if (aw_fire || w_fire) begin
          wr_state_d = W_COLLECT;
        end
      end
      W_COLLECT: begin
        if (wr_commit) begin
          wr_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (b_fire) begin
          wr_state_d = W_IDLE;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  // AW/W holding registers and the registered write response
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      bresp_q   <= AXIL_RESP_OKAY;
    end else begin
      if (b_fire) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end else begin
        if (aw_fire) begin
          aw_held   <= 1'b1;
          aw_addr_q <= s_axil.awaddr;
        end
        if (w_fire) begin
          w_held   <= 1'b1;
          w_data_q <= s_axil.wdata;
        end
      end
      if (wr_commit) begin
        bresp_q <= wr_err ? AXIL_RESP_SLVERR : AXIL_RESP_OKAY;
      end
    end
  end

  // Read FSM state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_state <= R_IDLE;
    end else begin
      rd_state <= rd_state_d;
    end
  end

  // Read FSM next state; AR is only accepted while no read data is pending
  always_comb begin
    rd_state_d = rd_state;
    ar_rdy     = rdy_en && (rd_state == R_IDLE);
    ar_fire    = s_axil.arvalid && ar_rdy;
    case (rd_state)
      R_IDLE: begin
        if (ar_fire) begin
          rd_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (s_axil.rready) begin
          rd_state_d = R_IDLE;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  // Read response registers, captured alongside the RAM read on the AR handshake
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rresp_q  <= AXIL_RESP_OKAY;
      rd_err_q <= 1'b0;
    end else if (ar_fire) begin
      rresp_q  <= rd_err ? AXIL_RESP_SLVERR : AXIL_RESP_OKAY;
      rd_err_q <= rd_err;
    end
  end

  axil_ram_core #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .DATA_WIDTH  (DATA_WIDTH)
  ) u_ram (
    .clk     (clk),
    .rstn    (rstn),
    .wr_en   (wr_commit && !wr_err),
    .wr_idx  (wr_idx),
    .wr_data (wr_data),
    .rd_en   (ar_fire),
    .rd_idx  (rd_idx),
    .rd_data (ram_rd_data)
  );

  assign s_axil.awready = aw_rdy;
  assign s_axil.wready  = w_rdy;
  assign s_axil.bvalid  = (wr_state == W_RESP);
  assign s_axil.bresp   = bresp_q;
  assign s_axil.arready = ar_rdy;
  assign s_axil.rvalid  = (rd_state == R_DATA);
  assign s_axil.rresp   = rresp_q;
  assign s_axil.rdata   = rd_err_q ? '0 : ram_rd_data;

endmodule

// File: tb/tb_axil_ram_slave.sv
// Randomised and directed bench for axil_ram_slave against a word-array reference model.
// Latency and hold rules are checked cycle by cycle inside the channel tasks.
// Honours AXIL_RAM_SLAVE_ERR_EN for expected responses.
module tb_axil_ram_slave;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 1024;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   cyc_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt++;

  axil_ram_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axil_ram_slave #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .DEPTH_WORDS (DEPTH),
    .BASE_ADDR   (32'h0000_0000)
  ) dut (
    .clk    (clk),
    .rstn   (rstn),
    .s_axil (bus)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] ref_mem [DEPTH];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference rules: base 0, 4-byte words, wrap at DEPTH, optional out-of-window error
  function automatic bit exp_err(input logic [31:0] a);
`ifdef AXIL_RAM_SLAVE_ERR_EN
    return a >= 32'(4 * DEPTH);
`else
    return (a == 32'hFFFF_FFFF) && (a != a);
`endif
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  // One write transaction; checks holding readies and one-cycle B latency each cycle
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input int aw_dly, input int w_dly, input int b_dly,
                           output logic [1:0] resp, output int commit_cyc);
    bit aw_done, w_done, b_done, b_seen;
    int k, bv_k, commit_k;
    aw_done = 0; w_done = 0; b_done = 0; b_seen = 0;
    k = 0; bv_k = 0; commit_k = -1; commit_cyc = -1; resp = 2'bxx;
    while (!b_done && k < 100) begin
      bus.awaddr  = addr;
      bus.wdata   = data;
      bus.awvalid = !aw_done && (k >= aw_dly);
      bus.wvalid  = !w_done && (k >= w_dly);
      bus.bready  = (b_dly == 0) || (b_seen && (k >= bv_k + b_dly));
      @(negedge clk);
      if (aw_done) check("awready_while_held", 32'(bus.awready), 0);
      if (w_done)  check("wready_while_held", 32'(bus.wready), 0);
      if (commit_k < 0) check("bvalid_before_commit", 32'(bus.bvalid), 0);
      else              check("bvalid_after_commit", 32'(bus.bvalid), 1);
      if (bus.bvalid && !b_seen) begin b_seen = 1; bv_k = k; end
      if (bus.bvalid && bus.bready) begin b_done = 1; resp = bus.bresp; end
      if (bus.awvalid && bus.awready) aw_done = 1;
      if (bus.wvalid && bus.wready)   w_done = 1;
      if (aw_done && w_done && commit_k < 0) begin commit_k = k; commit_cyc = cyc_cnt; end
      @(posedge clk); #1;
      k++;
    end
    bus.awvalid = 0; bus.wvalid = 0; bus.bready = 0;
    if (!b_done) check("write_timeout", 0, 1);
  endtask

  // One read transaction; checks R latency, arready low and R stability while stalled
  task automatic axi_read(input logic [31:0] addr, input int ar_dly, input int r_dly,
                          output logic [31:0] data, output logic [1:0] resp, output int commit_cyc);
    bit ar_done, r_done, r_seen;
    int k, rv_k;
    logic [31:0] first_data;
    logic [1:0]  first_resp;
    ar_done = 0; r_done = 0; r_seen = 0; k = 0; rv_k = 0;
    commit_cyc = -1; data = 'x; resp = 2'bxx; first_data = '0; first_resp = '0;
    while (!r_done && k < 100) begin
      bus.araddr  = addr;
      bus.arvalid = !ar_done && (k >= ar_dly);
      bus.rready  = (r_dly == 0) || (r_seen && (k >= rv_k + r_dly));
      @(negedge clk);
      if (!ar_done) check("rvalid_before_ar", 32'(bus.rvalid), 0);
      else begin
        check("rvalid_after_ar", 32'(bus.rvalid), 1);
        check("arready_while_rvalid", 32'(bus.arready), 0);
      end
      if (r_seen) begin
        check("rdata_stable", bus.rdata, first_data);
        check("rresp_stable", 32'(bus.rresp), 32'(first_resp));
      end
      if (bus.rvalid && !r_seen) begin
        r_seen = 1; rv_k = k; first_data = bus.rdata; first_resp = bus.rresp;
      end
      if (bus.rvalid && bus.rready) begin r_done = 1; data = bus.rdata; resp = bus.rresp; end
      if (bus.arvalid && bus.arready && !ar_done) begin ar_done = 1; commit_cyc = cyc_cnt; end
      @(posedge clk); #1;
      k++;
    end
    bus.arvalid = 0; bus.rready = 0;
    if (!r_done) check("read_timeout", 0, 1);
  endtask

  task automatic do_wr(input logic [31:0] addr, input logic [31:0] data,
                       input int aw_dly, input int w_dly, input int b_dly);
    logic [1:0] resp;
    int         cc;
    axi_write(addr, data, aw_dly, w_dly, b_dly, resp, cc);
    check("bresp", 32'(resp), exp_err(addr) ? 32'h2 : 32'h0);
    if (!exp_err(addr)) ref_mem[widx(addr)] = data;
  endtask

  task automatic do_rd(input logic [31:0] addr, input int ar_dly, input int r_dly);
    logic [31:0] data;
    logic [1:0]  resp;
    int          cc;
    axi_read(addr, ar_dly, r_dly, data, resp, cc);
    check("rresp", 32'(resp), exp_err(addr) ? 32'h2 : 32'h0);
    check("rdata", data, exp_err(addr) ? 32'h0 : ref_mem[widx(addr)]);
  endtask

  // Concurrent write and read; a read registered no later than the write sees the old word
  task automatic do_pair(input logic [31:0] waddr, input logic [31:0] wdata, input logic [31:0] raddr,
                         input int aw_dly, input int w_dly, input int ar_dly,
                         output logic [31:0] rdata, output int wc, output int rc);
    logic [31:0] old_val, exp_val;
    logic [1:0]  bresp, rresp;
    old_val = ref_mem[widx(raddr)];
    fork
      axi_write(waddr, wdata, aw_dly, w_dly, 0, bresp, wc);
      axi_read(raddr, ar_dly, 0, rdata, rresp, rc);
    join
    check("pair_bresp", 32'(bresp), exp_err(waddr) ? 32'h2 : 32'h0);
    if (!exp_err(waddr)) ref_mem[widx(waddr)] = wdata;
    exp_val = exp_err(raddr) ? 32'h0 : ((rc <= wc) ? old_val : ref_mem[widx(raddr)]);
    check("pair_rresp", 32'(rresp), exp_err(raddr) ? 32'h2 : 32'h0);
    check("pair_rdata", rdata, exp_val);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = 32'($urandom_range(0, 31)) * 4 + 32'($urandom_range(0, 3));
    if ($urandom_range(0, 7) == 0) a = a + 32'h1000;
    return a;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d, d2;
    logic [1:0]  r;
    int          c1, c2, wc, rc;

    bus.awaddr = '0; bus.awvalid = 0; bus.wdata = '0; bus.wvalid = 0; bus.bready = 0;
    bus.araddr = '0; bus.arvalid = 0; bus.rready = 0;

    // Reset values and the release edge
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_awready", 32'(bus.awready), 0);
    check("rst_wready",  32'(bus.wready), 0);
    check("rst_arready", 32'(bus.arready), 0);
    check("rst_bvalid",  32'(bus.bvalid), 0);
    check("rst_rvalid",  32'(bus.rvalid), 0);
    check("rst_bresp",   32'(bus.bresp), 0);
    check("rst_rresp",   32'(bus.rresp), 0);
    check("rst_rdata",   bus.rdata, 0);
    rstn = 1;
    #1;
    check("release_awready_low", 32'(bus.awready), 0);
    check("release_arready_low", 32'(bus.arready), 0);
    @(posedge clk); #1;
    check("ready_aw_after_edge", 32'(bus.awready), 1);
    check("ready_w_after_edge",  32'(bus.wready), 1);
    check("ready_ar_after_edge", 32'(bus.arready), 1);

    // Fill the test window with random words, varying AW/W order
    for (int i = 0; i < 32; i++)
      do_wr(32'(i * 4), $urandom, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 1));

    // Same-cycle AW+W, then read back
    do_wr(32'h10, 32'hCAFE_BABE, 0, 0, 0);
    do_rd(32'h10, 0, 0);

    // W three cycles ahead of AW, B stalled four cycles
    do_wr(32'h20, 32'h1234_5678, 3, 0, 4);
    do_rd(32'h20, 0, 0);

    // Read with R stalled five cycles
    do_rd(32'h30, 0, 5);

    // Same-cycle read/write to one word returns the old value
    do_wr(32'h40, 32'h0, 0, 0, 0);
    do_pair(32'h40, 32'h44, 32'h40, 0, 0, 0, d, wc, rc);
    check("same_cycle_commit", 32'(rc), 32'(wc));
    check("same_cycle_old_data", d, 32'h0);
    do_rd(32'h40, 0, 0);

    // Address one word past the window
    do_wr(32'h1000, 32'hDEAD_BEEF, 0, 0, 0);
    do_rd(32'h0, 0, 0);
    do_rd(32'h1000, 0, 0);

    // Back-to-back reads: one per two cycles
    axi_read(32'h10, 0, 0, d, r, c1);
    axi_read(32'h14, 0, 0, d2, r, c2);
    check("b2b_read_spacing", 32'(c2 - c1), 2);
    check("b2b_rdata0", d, ref_mem[4]);
    check("b2b_rdata1", d2, ref_mem[5]);

    // Randomised mix of writes, reads and overlapping pairs
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 2))
        0: do_wr(rand_addr(), $urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
        1: do_rd(rand_addr(), $urandom_range(0, 3), $urandom_range(0, 2));
        default: do_pair(rand_addr(), $urandom, rand_addr(),
                         $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), d, wc, rc);
      endcase
    end

    // Reset while an AW is held and read data is pending
    do_wr(32'h10, 32'hCAFE_BABE, 0, 0, 0);
    bus.awaddr = 32'h50; bus.awvalid = 1;
    bus.araddr = 32'h10; bus.arvalid = 1; bus.rready = 0;
    @(posedge clk); #1;
    bus.awvalid = 0; bus.arvalid = 0;
    @(negedge clk);
    check("pre_rst_rvalid",  32'(bus.rvalid), 1);
    check("pre_rst_awready", 32'(bus.awready), 0);
    #2 rstn = 0;
    #1;
    check("mid_rst_awready", 32'(bus.awready), 0);
    check("mid_rst_wready",  32'(bus.wready), 0);
    check("mid_rst_arready", 32'(bus.arready), 0);
    check("mid_rst_bvalid",  32'(bus.bvalid), 0);
    check("mid_rst_rvalid",  32'(bus.rvalid), 0);
    check("mid_rst_rdata",   bus.rdata, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1;
    #1;
    check("rerelease_awready_low", 32'(bus.awready), 0);
    @(posedge clk); #1;
    check("rerelease_awready", 32'(bus.awready), 1);
    check("rerelease_bvalid",  32'(bus.bvalid), 0);
    do_rd(32'h10, 0, 0);
    check("rst_keeps_mem", ref_mem[4], 32'hCAFE_BABE);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
